// File: rtl/fifo_lane_drain.sv
// Read-side consumer for the 8-deep async FIFO: pops len words per frame and serializes each
// word into simd lanes of bw bits on a valid/ready stream, lane 0 first.
module fifo_lane_drain #(
  parameter int unsigned bw   = 4,
  parameter int unsigned simd = 1,
  parameter int unsigned lw   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [simd*bw-1:0] fifo_out,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic               start,
  input  logic [lw-1:0]      len,
  output logic               busy,
  output logic [bw-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned LaneW = (simd > 1) ? $clog2(simd) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(simd - 1);

  localparam logic [2:0] StHold  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StFetch = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               hold_cnt_q, hold_cnt_d;
  logic [LaneW-1:0]   lane_idx_q, lane_idx_d;
  logic [lw-1:0]      remaining_q, remaining_d;
  logic [simd*bw-1:0] buffer_q, buffer_d;
  logic [simd*bw-1:0] lane_shifted;
  logic               handshake;
  logic               at_last_lane;

  // Pop only from registered state so consecutive pops are always >= 2 cycles apart.
  assign fifo_rd      = (state_q == StFetch) && !fifo_empty;
  assign busy         = (state_q != StIdle);
  assign out_valid    = (state_q == StShift);
  assign done         = (state_q == StDone);
  assign at_last_lane = (lane_idx_q == LastLane);
  assign out_last     = out_valid && at_last_lane && (remaining_q == '0);
  assign handshake    = out_valid && out_ready;
  assign lane_shifted = buffer_q >> (lane_idx_q * bw);
  assign out_data     = out_valid ? lane_shifted[bw-1:0] : '0;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    lane_idx_d  = lane_idx_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
    unique case (state_q)
      StHold: begin
        // The FIFO's empty flag is not trustworthy until two cycles after reset.
        if (hold_cnt_q) state_d = StIdle;
        else            hold_cnt_d = 1'b1;
      end
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            state_d     = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (fifo_rd) begin
          buffer_d    = fifo_out;
          remaining_d = remaining_q - lw'(1);
          lane_idx_d  = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (handshake) begin
          if (!at_last_lane)            lane_idx_d = lane_idx_q + LaneW'(1);
          else if (remaining_q != '0)   state_d = StFetch;
          else                          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= 1'b0;
      lane_idx_q  <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      lane_idx_q  <= lane_idx_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
    end
  end

endmodule

// File: tb/tb_fifo_lane_drain.sv
// Bench for fifo_lane_drain (simd=4, bw=4): queue-based FIFO model feeding the DUT and a
// lane-list reference built from the words written into each frame.
module tb_fifo_lane_drain;

  localparam int BW = 4;
  localparam int SIMD = 4;
  localparam int LW = 8;
  localparam int W = SIMD * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  fifo_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  fq[$];
  logic [W-1:0]  exp_words[$];
  logic [BW-1:0] exp_lanes[$];
  logic [BW-1:0] got_lanes[$];
  bit            got_last[$];
  bit            ready_pat[$];
  int pops, dones, min_gap, first_pop, first_valid, done_c, hold_viol;
  bit timed_out;

  fifo_lane_drain #(.bw(BW), .simd(SIMD), .lw(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // FIFO read side: head word and empty flag change only on clock edges.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) fq.delete(0);
    fifo_empty <= (fq.size() == 0);
    fifo_out   <= (fq.size() > 0) ? fq[0] : '0;
  end

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic new_frame();
    fq.delete();
    exp_words.delete();
  endtask

  // Expected stream: every word split into SIMD lanes, least-significant lane first.
  task automatic model_lanes();
    exp_lanes.delete();
    foreach (exp_words[k])
      for (int l = 0; l < SIMD; l++) exp_lanes.push_back(BW'((exp_words[k] >> (l * BW)) & 'hF));
  endtask

  task automatic start_frame(input int n);
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs the stream until done (plus one cycle) or until the budget expires.
  task automatic collect(input int max_cyc, input bit rnd_ready, input bit noise);
    bit prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    int last_pop = -1;
    got_lanes.delete(); got_last.delete();
    pops = 0; dones = 0; min_gap = 1 << 30; first_pop = -1; first_valid = -1;
    done_c = -1; hold_viol = 0; timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else if (c < ready_pat.size()) out_ready = ready_pat[c];
      else out_ready = 1'b1;
      if (noise) begin start = 1'($urandom_range(0, 1)); len = LW'($urandom); end
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data)) hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) begin
        got_lanes.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (fifo_rd) begin
        if (last_pop >= 0 && c - last_pop < min_gap) min_gap = c - last_pop;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      if (done) begin
        dones++; done_c = c; timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!timed_out) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
    new_frame();
    push_word(16'h1111);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    reset = 1'b0; start = 1'b1; len = LW'(1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (fifo_rd !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL hold_%0d: got rd=%b busy=%b want rd=0 busy=1", i, fifo_rd, busy);
      end
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    start = 1'b0;
    #1;
    checks++; if (fq.size() != 1) begin errors++; $display("FAIL hold_nopop: got %0d words want 1", fq.size()); end
  endtask

  task automatic test_serialize();
    new_frame();
    push_word(16'hDCBA);
    model_lanes();
    start_frame(1);
    collect(40, 1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL ser_timeout: got timeout want done"); end
    checks++; if (pops != 1) begin errors++; $display("FAIL ser_pops: got %0d want 1", pops); end
    checks++; if (first_pop != 0) begin errors++; $display("FAIL ser_pop_lat: got %0d want 0", first_pop); end
    checks++; if (first_valid != 1) begin errors++; $display("FAIL ser_val_lat: got %0d want 1", first_valid); end
    checks++; if (done_c != SIMD + 1) begin errors++; $display("FAIL ser_done_c: got %0d want %0d", done_c, SIMD + 1); end
    checks++; if (dones != 1) begin errors++; $display("FAIL ser_done_w: got %0d want 1", dones); end
    checks++; if (got_lanes.size() != exp_lanes.size()) begin
      errors++; $display("FAIL ser_count: got %0d want %0d", got_lanes.size(), exp_lanes.size());
    end else for (int i = 0; i < got_lanes.size(); i++) begin
      checks++; if (got_lanes[i] !== exp_lanes[i]) begin errors++; $display("FAIL ser_lane%0d: got %h want %h", i, got_lanes[i], exp_lanes[i]); end
      checks++; if (got_last[i] !== (i == got_lanes.size() - 1)) begin errors++; $display("FAIL ser_last%0d: got %b", i, got_last[i]); end
    end
  endtask

  task automatic test_multi_word();
    new_frame();
    push_word(16'h4321); push_word(16'h8765); push_word(16'hCBA9);
    model_lanes();
    start_frame(3);
    collect(80, 1'b0, 1'b0);
    checks++; if (pops != 3) begin errors++; $display("FAIL mw_pops: got %0d want 3", pops); end
    checks++; if (min_gap != SIMD + 1) begin errors++; $display("FAIL mw_gap: got %0d want %0d", min_gap, SIMD + 1); end
    checks++; if (done_c != 3 * (SIMD + 1)) begin errors++; $display("FAIL mw_done_c: got %0d want %0d", done_c, 3 * (SIMD + 1)); end
    checks++; if (got_lanes.size() != exp_lanes.size()) begin
      errors++; $display("FAIL mw_count: got %0d want %0d", got_lanes.size(), exp_lanes.size());
    end else for (int i = 0; i < got_lanes.size(); i++) begin
      checks++; if (got_lanes[i] !== exp_lanes[i]) begin errors++; $display("FAIL mw_lane%0d: got %h want %h", i, got_lanes[i], exp_lanes[i]); end
      checks++; if (got_last[i] !== (i == got_lanes.size() - 1)) begin errors++; $display("FAIL mw_last%0d: got %b", i, got_last[i]); end
    end
  endtask

  task automatic test_backpressure();
    new_frame();
    push_word(16'h5A3C);
    model_lanes();
    ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    start_frame(1);
    collect(40, 1'b0, 1'b0);
    ready_pat.delete();
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); end
    checks++; if (pops != 1) begin errors++; $display("FAIL bp_pops: got %0d want 1", pops); end
    checks++; if (done_c != SIMD + 3) begin errors++; $display("FAIL bp_done_c: got %0d want %0d", done_c, SIMD + 3); end
    checks++; if (got_lanes.size() != exp_lanes.size()) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", got_lanes.size(), exp_lanes.size());
    end else for (int i = 0; i < got_lanes.size(); i++) begin
      checks++; if (got_lanes[i] !== exp_lanes[i]) begin errors++; $display("FAIL bp_lane%0d: got %h want %h", i, got_lanes[i], exp_lanes[i]); end
    end
  endtask

  task automatic test_starve_zero();
    new_frame();
    push_word(16'h2468);
    start_frame(2);
    collect(30, 1'b0, 1'b0);
    checks++; if (!timed_out) begin errors++; $display("FAIL st_wait: got done want waiting"); end
    checks++; if (pops != 1) begin errors++; $display("FAIL st_pops1: got %0d want 1", pops); end
    checks++; if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL st_idle: got rd=%b valid=%b busy=%b want 0 0 1", fifo_rd, out_valid, busy);
    end
    push_word(16'h9BDF);
    model_lanes();
    collect(40, 1'b0, 1'b0);
    checks++; if (timed_out || pops != 1) begin errors++; $display("FAIL st_resume: got pops=%0d to=%b want 1 0", pops, timed_out); end
    checks++; if (got_lanes.size() != SIMD) begin
      errors++; $display("FAIL st_count: got %0d want %0d", got_lanes.size(), SIMD);
    end else for (int i = 0; i < SIMD; i++) begin
      checks++; if (got_lanes[i] !== exp_lanes[SIMD + i]) begin errors++; $display("FAIL st_lane%0d: got %h want %h", i, got_lanes[i], exp_lanes[SIMD + i]); end
      checks++; if (got_last[i] !== (i == SIMD - 1)) begin errors++; $display("FAIL st_last%0d: got %b", i, got_last[i]); end
    end
    new_frame();
    push_word(16'h7777);
    start_frame(0);
    collect(10, 1'b0, 1'b0);
    checks++; if (done_c != 0 || dones != 1) begin errors++; $display("FAIL z_done: got c=%0d n=%0d want 0 1", done_c, dones); end
    checks++; if (pops != 0 || got_lanes.size() != 0) begin errors++; $display("FAIL z_pops: got %0d pops %0d lanes want 0", pops, got_lanes.size()); end
  endtask

  task automatic test_reset_mid();
    new_frame();
    push_word(16'hF0E1); push_word(16'h3322);
    start_frame(2);
    out_ready = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL rm_pop: got %b want 1", fifo_rd); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hE) begin
      errors++; $display("FAIL rm_lane1: got v=%b d=%h want 1 e", out_valid, out_data);
    end
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || fifo_rd !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rm_hold: got v=%b rd=%b busy=%b want 0 0 1", out_valid, fifo_rd, busy);
    end
    reset = 1'b0;
    new_frame();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got busy=%b want 0", busy); end
    push_word(16'hA5C3);
    model_lanes();
    start_frame(1);
    collect(40, 1'b0, 1'b0);
    checks++; if (pops != 1 || timed_out) begin errors++; $display("FAIL rm_pops: got %0d to=%b want 1 0", pops, timed_out); end
    checks++; if (got_lanes.size() != exp_lanes.size()) begin
      errors++; $display("FAIL rm_count: got %0d want %0d", got_lanes.size(), exp_lanes.size());
    end else for (int i = 0; i < got_lanes.size(); i++) begin
      checks++; if (got_lanes[i] !== exp_lanes[i]) begin errors++; $display("FAIL rm_lane%0d: got %h want %h", i, got_lanes[i], exp_lanes[i]); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 4);
      new_frame();
      for (int k = 0; k < n; k++) push_word(W'($urandom));
      model_lanes();
      start_frame(n);
      collect(300, 1'b1, 1'b1);
      checks++; if (timed_out || dones != 1) begin errors++; $display("FAIL rnd%0d_done: got to=%b n=%0d want 0 1", f, timed_out, dones); end
      checks++; if (pops != n) begin errors++; $display("FAIL rnd%0d_pops: got %0d want %0d", f, pops, n); end
      checks++; if (n > 1 && min_gap < 2) begin errors++; $display("FAIL rnd%0d_gap: got %0d want >=2", f, min_gap); end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d want 0", f, hold_viol); end
      checks++; if (got_lanes.size() != exp_lanes.size()) begin
        errors++; $display("FAIL rnd%0d_count: got %0d want %0d", f, got_lanes.size(), exp_lanes.size());
      end else for (int i = 0; i < got_lanes.size(); i++) begin
        checks++; if (got_lanes[i] !== exp_lanes[i]) begin errors++; $display("FAIL rnd%0d_lane%0d: got %h want %h", f, i, got_lanes[i], exp_lanes[i]); end
        checks++; if (got_last[i] !== (i == got_lanes.size() - 1)) begin errors++; $display("FAIL rnd%0d_last%0d: got %b", f, i, got_last[i]); end
      end
      checks++; if (fq.size() != 0) begin errors++; $display("FAIL rnd%0d_left: got %0d words want 0", f, fq.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_multi_word();
    test_backpressure();
    test_starve_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_lane_drain.md
Name: fifo_lane_drain

Overview:
- Single-clock consumer stage on the read side of the team's 8-deep asynchronous FIFO.
- Pops frames of len words of simd*bw bits each from the FIFO read port.
- Serializes each word into simd lanes of bw bits on a valid/ready stream, lane 0 first.
- Flags the last lane of each frame and pulses done when the frame completes.

Parameters:
bw, 4, lane width in bits
simd, 1, lanes per FIFO word (>=1)
lw, 8, width of frame-length input

Ports:
clk  input  1  read-domain clock, same clock as the FIFO rd_clk
reset  input  1  synchronous, active-high reset
fifo_out  input  simd*bw  FIFO read data, valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag (registered in the FIFO)
fifo_rd  output  1  FIFO pop strobe
start  input  1  frame start request, sampled on clk
len  input  lw  words in the frame, sampled with start
busy  output  1  high in any state other than IDLE
out_data  output  bw  current lane
out_valid  output  1  out_data valid
out_ready  input  1  downstream accept
out_last  output  1  last lane of the last word of the frame
done  output  1  one-cycle frame-complete pulse

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset values: state=HOLD, hold_cnt=0, fifo_rd=0, out_valid=0, out_last=0, done=0, busy=1, out_data=0, lane_idx=0, remaining=0, buffer=0.
- HOLD: 2 cycles after reset.
  - The FIFO's empty flag is invalid during this window.
  - fifo_rd is forced 0 and start is ignored.
  - Then go to IDLE.
- IDLE: busy=0.
  - start=1 with len!=0: load remaining=len and go to FETCH.
  - start=1 with len=0: go to DONE. No pop occurs.
- FETCH:
  - fifo_rd = (state==FETCH) && !fifo_empty. This is combinational from registered state and fifo_empty.
  - On that edge: buffer<=fifo_out, remaining<=remaining-1, lane_idx<=0, go to SHIFT.
  - If fifo_empty=1, stay in FETCH with fifo_rd=0.
- SHIFT:
  - out_valid=1; out_data=buffer[lane_idx*bw +: bw] (lane 0 = bits [bw-1:0]).
  - out_valid and out_data are held stable until out_valid&&out_ready.
  - On a handshake with lane_idx<simd-1: lane_idx+1.
  - On a handshake with lane_idx==simd-1: go to FETCH if remaining!=0, else go to DONE.
  - out_last = out_valid && lane_idx==simd-1 && remaining==0.
- DONE: done=1 for exactly 1 cycle, then IDLE.
- Pop spacing:
  - fifo_rd is high at most 1 cycle per word.
  - There are at least 2 cycles between consecutive pops, because SHIFT lasts >=1 cycle and FETCH follows.
  - This guarantees fifo_empty reflects the previous pop before it is sampled again.
  - fifo_rd is never asserted in HOLD, IDLE, SHIFT or DONE.
- Throughput: with out_ready held high, one word per simd+1 cycles.
- Latency:
  - FETCH is entered the cycle after start is sampled.
  - First out_valid appears the cycle after the first pop.
- Boundary and ordering rules:
  - start during busy: ignored; len is not resampled.
  - FIFO empty mid-frame: wait in FETCH indefinitely, with out_valid=0.
  - remaining and lane_idx never wrap. len is at most 2^lw-1.
  - Reset mid-frame: return to HOLD immediately. Buffered data is discarded with no further pops or outputs.
  - simd=1: each word is one lane, and out_last is high on the single lane of the final word.

Test Plan:
- Reset hold: reset then start=1 in cycle 1, FIFO non-empty -> fifo_rd=0 and busy=1 for 2 cycles; start ignored; IDLE reached.
- Serialize (simd=4, bw=4): FIFO holds 16'hDCBA, start with len=1, out_ready=1 -> one fifo_rd pulse.
  - out_data sequence is A,B,C,D on consecutive cycles; out_last only with D; done 1 cycle later.
- Multi-word (simd=2, bw=4): words 8'h21, 8'h43, 8'h65, len=3 -> lanes 1,2,3,4,5,6.
  - Exactly 3 pops, each at least 2 cycles apart; out_last only on 6.
- Backpressure: out_ready toggled 1,0,0,1 during lane 1 -> out_data is held at lane 1 while ready=0; no lane skipped or duplicated; no extra pop.
- Starvation and zero length:
  - len=2 with only one word written: ends waiting in FETCH, fifo_rd=0, out_valid=0.
  - After a second write arrives, it completes.
  - len=0 -> done on the 2nd cycle, no fifo_rd.
- Reset mid-frame: assert reset during SHIFT lane 1 -> next cycle out_valid=0, fifo_rd=0, state HOLD; a following frame drains correctly.
